// File: rtl/manchester_tx.sv
// Framed Manchester transmitter: valid/ready word input, optional 1010 preamble, then payload bits.
// Internal counters run one cycle ahead of the registered line outputs.
module manchester_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned HALF_DIV  = 1,
  parameter int unsigned PRE_LEN   = 4,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              encode_mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              tx_out_o,
  output logic              tx_en_o,
  output logic              done_o
);

  localparam int unsigned BitMax = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int unsigned BitW   = (BitMax > 1) ? $clog2(BitMax) : 1;
  localparam int unsigned DivW   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  localparam logic [BitW-1:0] PreLast  = BitW'(PRE_LEN - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_W - 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(HALF_DIV - 1);

  typedef enum logic [1:0] {StIdle, StPre, StData} state_e;

  state_e             state_q, state_d;
  logic [DivW-1:0]    div_q, div_d;
  logic               phase_q, phase_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               mode_q, mode_d;
  logic               tx_out_q, tx_out_d;
  logic               tx_en_q, tx_en_d;
  logic               fin_q, fin_d;
  logic               done_q, done_d;

  logic half_end, bit_end, last_clk, accept, cur_bit;

  always_comb begin
    half_end   = (div_q == DivLast);
    bit_end    = half_end & phase_q;
    last_clk   = (state_q == StData) & bit_end & (bit_q == DataLast);
    in_ready_o = rst_ni & ((state_q == StIdle) | last_clk);
    accept     = in_valid_i & in_ready_o;
  end

  always_comb begin
    cur_bit = 1'b0;
    case (state_q)
      StPre:   cur_bit = ~bit_q[0];
      StData:  cur_bit = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_W-1];
      default: cur_bit = 1'b0;
    endcase
    // Mode 0 sends b then ~b; mode 1 inverts both halves.
    tx_out_d = (state_q != StIdle) & (cur_bit ^ phase_q ^ mode_q);
    tx_en_d  = (state_q != StIdle);
    fin_d    = last_clk;
    done_d   = fin_q;
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    mode_d  = mode_q;

    if (state_q != StIdle) begin
      div_d   = half_end ? '0 : div_q + 1'b1;
      phase_d = phase_q ^ half_end;
    end

    case (state_q)
      StPre: begin
        if (bit_end) begin
          if (bit_q == PreLast) begin
            state_d = StData;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
          if (bit_q == DataLast) begin
            state_d = StIdle;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d = (PRE_LEN > 0) ? StPre : StData;
      shift_d = in_data_i;
      mode_d  = encode_mode_i;
      div_d   = '0;
      phase_d = 1'b0;
      bit_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      div_q    <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      shift_q  <= '0;
      mode_q   <= 1'b0;
      tx_out_q <= 1'b0;
      tx_en_q  <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      mode_q   <= mode_d;
      tx_out_q <= tx_out_d;
      tx_en_q  <= tx_en_d;
      fin_q    <= fin_d;
      done_q   <= done_d;
    end
  end

  assign tx_out_o = tx_out_q;
  assign tx_en_o  = tx_en_q;
  assign done_o   = done_q;

endmodule
